// File: rtl/time_disp_mux.sv
// time_disp_mux: BCD-converts two disp_time fields and scans a 4-digit active-low 7-seg display; BLINK_COLON_EN adds a 1 Hz dp blink
module time_disp_mux #(
    parameter int SCAN_DIV = 1
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [26:0] disp_time,
    input  logic        mode,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam logic [3:0] DASH = 4'hA;
    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [4:0] hr;
    logic [5:0] min, sec;
    logic [2:0] step;
    logic [5:0] hi_bin, lo_bin;
    logic [7:0] hi_bcd, lo_bcd;
    logic hi_bad, lo_bad;
    logic [3:0][3:0] pend, shown;
    logic pend_valid;
    logic [1:0] idx;
    logic [7:0] scnt;
    logic wrap, blink;
    assign hr = disp_time[26:22];
    assign min = disp_time[21:16];
    assign sec = disp_time[15:10];
    assign wrap = scnt == SCAN_LAST;
    function automatic logic [7:0] adj3(input logic [7:0] b);
        return {b[7:4] >= 4'd5 ? b[7:4] + 4'd3 : b[7:4], b[3:0] >= 4'd5 ? b[3:0] + 4'd3 : b[3:0]};
    endfunction
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            DASH: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction
    always_comb begin
        state_nx = state == IDLE  ? LOAD :
                   state == LOAD  ? SHIFT :
                   state == SHIFT ? (step == 3'd5 ? DONE : SHIFT) : LOAD;
    end
`ifdef BLINK_COLON_EN
    logic ms_low;
    always_ff @(posedge kh_clk) begin
        if (reset)
            ms_low <= 1'b0;
        else if (state == LOAD)
            ms_low <= disp_time[9:0] < 10'd500;
    end
    assign blink = idx == 2'd2 && ms_low;
`else
    logic unused_ms;
    assign unused_ms = ^disp_time[9:0];
    assign blink = 1'b0;
`endif
    always_ff @(posedge kh_clk) begin
        if (reset) begin
            state <= IDLE;
            step <= 3'd0;
            hi_bin <= 6'd0;
            lo_bin <= 6'd0;
            hi_bcd <= 8'd0;
            lo_bcd <= 8'd0;
            hi_bad <= 1'b0;
            lo_bad <= 1'b0;
            pend <= {4{BLANK}};
            shown <= {4{BLANK}};
            pend_valid <= 1'b0;
            idx <= 2'd0;
            scnt <= 8'd0;
            an <= 4'hF;
            seg <= 7'h7F;
            dp <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == LOAD) begin
                hi_bin <= mode ? min : {1'b0, hr};
                lo_bin <= mode ? sec : min;
                hi_bcd <= 8'd0;
                lo_bcd <= 8'd0;
                hi_bad <= mode ? min > 6'd59 : hr > 5'd23;
                lo_bad <= (mode ? sec : min) > 6'd59;
                step <= 3'd0;
            end
            if (state == SHIFT) begin
                {hi_bcd, hi_bin} <= {adj3(hi_bcd), hi_bin} << 1;
                {lo_bcd, lo_bin} <= {adj3(lo_bcd), lo_bin} << 1;
                step <= step + 3'd1;
            end
            scnt <= wrap ? 8'd0 : scnt + 8'd1;
            if (wrap) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3 && pend_valid) begin
                    shown <= pend;
                    pend_valid <= 1'b0;
                end
            end
            // Placed after the commit so a same-cycle DONE re-arms pend_valid for the next frame
            if (state == DONE) begin
                pend <= {hi_bad ? {DASH, DASH} : hi_bcd, lo_bad ? {DASH, DASH} : lo_bcd};
                pend_valid <= 1'b1;
            end
            an <= ~(4'b0001 << idx);
            seg <= decode(shown[idx]);
            dp <= ~blink;
        end
    end
endmodule

// File: tb/tb_time_disp_mux.sv
// tb_time_disp_mux: randomized and directed checks of time_disp_mux against a cycle-count reference model
module tb_time_disp_mux;
    localparam int SD = 1;
    logic kh_clk = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0;
    logic [26:0] disp_time = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    int tests = 0;
    int fails = 0;
    int t = 0;
    int last_idx = 0;
    int shown[4], pend[4], conv[4];
    bit pv = 0;
    bit ms_lt = 0;
    logic [6:0] seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    time_disp_mux #(.SCAN_DIV(SD)) dut (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time), .mode(mode),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 kh_clk = ~kh_clk;

    function automatic logic [26:0] pack(input int h, input int m, input int s, input int ms);
        return {5'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s t=%0d got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // One clock: the model counts edges since reset release; conversions sample
    // at t%8==1, land in pending at t%8==0, and frames commit at their last slot.
    task automatic tick(input bit rs);
        logic [3:0] ean;
        logic [6:0] eseg;
        logic edp;
        int hv, lv;
        bit hb, lb;
        reset = rs;
        @(posedge kh_clk);
        if (rs) begin
            t = 0;
            pv = 0;
            ms_lt = 0;
            for (int i = 0; i < 4; i++) begin
                shown[i] = 15;
                pend[i] = 15;
            end
            ean = 4'hF;
            eseg = 7'h7F;
            edp = 1'b1;
        end else begin
            last_idx = (t / SD) % 4;
            ean = ~(4'b0001 << last_idx);
            eseg = seg_tab[shown[last_idx]];
`ifdef BLINK_COLON_EN
            edp = !(last_idx == 2 && ms_lt);
`else
            edp = 1'b1;
`endif
            if (t % (4 * SD) == 4 * SD - 1 && pv) begin
                shown = pend;
                pv = 0;
            end
            if (t > 0 && t % 8 == 0) begin
                pend = conv;
                pv = 1;
            end
            if (t % 8 == 1) begin
                hv = mode ? int'(disp_time[21:16]) : int'(disp_time[26:22]);
                lv = mode ? int'(disp_time[15:10]) : int'(disp_time[21:16]);
                hb = hv > (mode ? 59 : 23);
                lb = lv > 59;
                conv[3] = hb ? 10 : hv / 10;
                conv[2] = hb ? 10 : hv % 10;
                conv[1] = lb ? 10 : lv / 10;
                conv[0] = lb ? 10 : lv % 10;
                ms_lt = disp_time[9:0] < 10'd500;
            end
            t++;
        end
        #1;
        check("an", {28'd0, an}, {28'd0, ean});
        check("seg", {25'd0, seg}, {25'd0, eseg});
        check("dp", {31'd0, dp}, {31'd0, edp});
    endtask

    // e = {idx3, idx2, idx1, idx0} segment codes taken straight from the expected display
    task automatic steady(input string tag, input logic [27:0] e);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0);
            check(tag, {25'd0, seg}, {25'd0, e[last_idx*7 +: 7]});
        end
    endtask

    initial begin
        disp_time = pack(13, 45, 0, 0);
        mode = 1'b0;
        repeat (5) tick(1'b1);
        repeat (16) tick(1'b0);
        steady("hhmm_13_45", {7'h79, 7'h30, 7'h19, 7'h12});

        disp_time = pack(0, 7, 9, 0);
        mode = 1'b1;
        repeat (24) tick(1'b0);
        while (t % 8 != 3) tick(1'b0);
        mode = 1'b0;
        repeat (3) tick(1'b0);
        mode = 1'b1;
        repeat (20) tick(1'b0);
        steady("mmss_07_09", {7'h40, 7'h78, 7'h40, 7'h10});

        disp_time = pack(25, 30, 0, 0);
        mode = 1'b0;
        repeat (24) tick(1'b0);
        steady("range_25_30", {7'h3F, 7'h3F, 7'h30, 7'h40});

        disp_time = pack(23, 59, 0, 0);
        repeat (24) tick(1'b0);
        while (t % 4 != 2) tick(1'b0);
        disp_time = pack(0, 0, 0, 0);
        repeat (24) tick(1'b0);
        steady("wrap_00_00", {7'h40, 7'h40, 7'h40, 7'h40});

        disp_time = pack(12, 34, 56, 250);
        repeat (10) tick(1'b0);
        while (t % 8 != 4) tick(1'b0);
        tick(1'b1);
        repeat (24) tick(1'b0);
        disp_time = pack(12, 34, 56, 750);
        repeat (24) tick(1'b0);

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0)
                disp_time = pack($urandom_range(0, 31),
                                 $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(57, 61),
                                 $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(57, 61),
                                 $urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0)
                mode = ~mode;
            tick($urandom_range(0, 63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
